pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline control unit for the N-stage RV32I core.
- Replaces the gated-clock stall (clk && !stall) with per-register clock enables, flushes and valid tracking.
- Handles cache-miss stalls, EX-resolved branch/jump flushes and load-use interlocks.
- Sits beside the datapath in the core top; every pipeline register and the PC register take their enable/flush from it.

---
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Control-side bundle between the core datapath and pipe_hazard_ctrl.
// The datapath uses the master modport and the control unit uses the slave modport.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 32
);
  logic                  trigger;
  logic                  mem_stall;
  logic                  branch_taken;
  logic [4:0]            id_rs1;
  logic [4:0]            id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [4:0]            ex_rd;
  logic                  ex_mem_read;
  logic                  pc_en;
  logic [NUM_STAGES-2:0] stage_en;
  logic [NUM_STAGES-2:0] stage_flush;
  logic [NUM_STAGES-2:0] stage_valid;
  logic                  running;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;
  logic [CNT_W-1:0]      lu_count;

  modport master (
    output trigger, mem_stall, branch_taken, id_rs1, id_rs2,
           id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
    input  pc_en, stage_en, stage_flush, stage_valid, running,
           stall_count, flush_count, lu_count
  );

  modport slave (
    input  trigger, mem_stall, branch_taken, id_rs1, id_rs2,
           id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
    output pc_en, stage_en, stage_flush, stage_valid, running,
           stall_count, flush_count, lu_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: per-register enables/flushes, valid tracking, stall/flush/load-use handling.
// Define PIPE_PERF_CNT_EN to build the saturating performance counters; otherwise they read 0.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam int NR = NUM_STAGES - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [NR-1:0] valid_q, valid_d;
  logic [NR-1:0] stageEn, stageFlush;
  logic          pcEn;
  logic          active, stallHit, branchHit, loadUseHit, luHit;

  // Hazard detection; a branch only counts when EX actually holds a live instruction.
  always_comb begin
    active     = (state_q != IDLE);
    loadUseHit = bus.ex_mem_read && valid_q[1] && valid_q[0] && (bus.ex_rd != 5'd0) &&
                 ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                  (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
    stallHit   = active && bus.mem_stall;
    branchHit  = active && !bus.mem_stall && bus.branch_taken && valid_q[1];
    luHit      = active && !bus.mem_stall && !branchHit && loadUseHit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.trigger)    state_d = RUN;
      RUN:     if (bus.mem_stall)  state_d = MISS;
      MISS:    if (!bus.mem_stall) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Priority: memory stall freezes everything, then branch redirect, then load-use bubble.
  always_comb begin
    pcEn       = 1'b0;
    stageEn    = '1;
    stageFlush = '0;
    if (!active) begin
      stageFlush = '1;
    end else if (stallHit) begin
      stageEn = '0;
    end else if (branchHit) begin
      pcEn            = 1'b1;
      stageFlush[1:0] = 2'b11;
    end else if (luHit) begin
      stageEn[0]    = 1'b0;
      stageFlush[1] = 1'b1;
    end else begin
      pcEn = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (stageEn[0]) valid_d[0] = !stageFlush[0] && (state_q == RUN);
    for (int k = 1; k < NR; k++) begin
      if (stageEn[k]) valid_d[k] = !stageFlush[k] && valid_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  assign bus.pc_en       = pcEn;
  assign bus.stage_en    = stageEn;
  assign bus.stage_flush = stageFlush;
  assign bus.stage_valid = valid_q;
  assign bus.running     = active;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic [CNT_W-1:0] luCnt_q, luCnt_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    luCnt_d    = luCnt_q;
    if (stallHit  && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNT_W'(1);
    if (branchHit && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + CNT_W'(1);
    if (luHit     && (luCnt_q    != '1)) luCnt_d    = luCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
      luCnt_q    <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
      luCnt_q    <= luCnt_d;
    end
  end

  assign bus.stall_count = stallCnt_q;
  assign bus.flush_count = flushCnt_q;
  assign bus.lu_count    = luCnt_q;
`else
  assign bus.stall_count = '0;
  assign bus.flush_count = '0;
  assign bus.lu_count    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared against an action-level pipeline occupancy model.
module tb_pipe_hazard_ctrl;
  localparam int NS = 5;
  localparam int NR = NS - 1;
  localparam int CW = 32;
  localparam logic [NR-1:0] ALL = '1;

  typedef enum int {ACT_IDLE, ACT_HOLD, ACT_REDIRECT, ACT_INTERLOCK, ACT_ADVANCE} act_e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();
  pipe_hazard_ctrl #(.NUM_STAGES(NS), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int            errors = 0;
  int            checks = 0;
  int            mState;
  logic [NR-1:0] mValid;
  longint        mStallCnt, mFlushCnt, mLuCnt;
  act_e          act;
  logic          expPcEn, expRunning;
  logic [NR-1:0] expEn, expFlush;
  logic [3*CW-1:0] expCnt;

  // Model reset: idle, empty pipeline, zeroed counters.
  task automatic resetModel();
    mState    = 0;
    mValid    = '0;
    mStallCnt = 0;
    mFlushCnt = 0;
    mLuCnt    = 0;
  endtask

  // Which response the control rules demand this cycle.
  function automatic act_e decide();
    logic hazard;
    hazard = bus.ex_mem_read && mValid[1] && mValid[0] && (bus.ex_rd != 5'd0) &&
             ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    if (mState == 0)                       return ACT_IDLE;
    else if (bus.mem_stall)                return ACT_HOLD;
    else if (bus.branch_taken && mValid[1]) return ACT_REDIRECT;
    else if (hazard)                       return ACT_INTERLOCK;
    else                                   return ACT_ADVANCE;
  endfunction

  // Drive one cycle's inputs after the falling edge, then derive expectations.
  task automatic applyStimulus(input logic trig, input logic ms, input logic br, input logic ld,
                               input logic u1, input logic u2, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] exrd);
    @(negedge clk);
    bus.trigger      = trig;
    bus.mem_stall    = ms;
    bus.branch_taken = br;
    bus.ex_mem_read  = ld;
    bus.id_uses_rs1  = u1;
    bus.id_uses_rs2  = u2;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.ex_rd        = exrd;
    #1;
    act        = decide();
    expPcEn    = (act == ACT_REDIRECT) || (act == ACT_ADVANCE);
    expEn      = (act == ACT_HOLD) ? '0 : (act == ACT_INTERLOCK) ? (ALL & ~NR'(1)) : ALL;
    expFlush   = (act == ACT_IDLE) ? ALL : (act == ACT_REDIRECT) ? NR'(3) :
                 (act == ACT_INTERLOCK) ? NR'(2) : '0;
    expRunning = (mState != 0);
`ifdef PIPE_PERF_CNT_EN
    expCnt = {mStallCnt[CW-1:0], mFlushCnt[CW-1:0], mLuCnt[CW-1:0]};
`else
    expCnt = '0;
`endif
  endtask

  // Clock edge: occupancy moves as a whole according to the chosen action.
  task automatic tick();
    logic [NR-1:0] shifted;
    logic [NR-1:0] inj;
    longint        cmax;
    @(posedge clk);
    cmax    = (longint'(1) << CW) - 1;
    shifted = mValid << 1;
    inj     = (mState == 1) ? NR'(1) : '0;
    if (mState != 0 && bus.mem_stall && mStallCnt < cmax) mStallCnt++;
    if (act == ACT_REDIRECT && mFlushCnt < cmax) mFlushCnt++;
    if (act == ACT_INTERLOCK && mLuCnt < cmax) mLuCnt++;
    case (act)
      ACT_IDLE:      mValid = '0;
      ACT_REDIRECT:  mValid = (shifted | inj) & ~NR'(3);
      ACT_INTERLOCK: mValid = (shifted & ~NR'(3)) | (mValid & NR'(1));
      ACT_ADVANCE:   mValid = shifted | inj;
      default:       mValid = mValid;
    endcase
    case (mState)
      0:       if (bus.trigger) mState = 1;
      1:       if (bus.mem_stall) mState = 2;
      default: if (!bus.mem_stall) mState = 1;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.trigger = 0; bus.mem_stall = 0; bus.branch_taken = 0; bus.ex_mem_read = 0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.ex_rd = 0;
    resetModel();
    #3;
    checks++; if ({bus.pc_en, bus.stage_en, bus.stage_flush} !== {1'b0, ALL, ALL}) begin
      errors++; $display("[TB] FAIL reset_ctrl got=%b exp=%b", {bus.pc_en, bus.stage_en, bus.stage_flush}, {1'b0, ALL, ALL}); end
    checks++; if ({bus.running, bus.stage_valid} !== {1'b0, NR'(0)}) begin
      errors++; $display("[TB] FAIL reset_state got=%b exp=0", {bus.running, bus.stage_valid}); end
    checks++; if ({bus.stall_count, bus.flush_count, bus.lu_count} !== '0) begin
      errors++; $display("[TB] FAIL reset_counters got=%h exp=0", {bus.stall_count, bus.flush_count, bus.lu_count}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({bus.pc_en, bus.stage_en, bus.stage_flush} !== {expPcEn, expEn, expFlush}) begin
      errors++; $display("[TB] FAIL fill_idle_ctrl got=%b exp=%b", {bus.pc_en, bus.stage_en, bus.stage_flush}, {expPcEn, expEn, expFlush}); end
    tick();
    for (int i = 0; i <= 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.stage_valid !== NR'((1 << i) - 1)) begin
        errors++; $display("[TB] FAIL fill_valid cyc=%0d got=%b exp=%b", i, bus.stage_valid, NR'((1 << i) - 1)); end
      checks++; if ({bus.running, bus.pc_en, bus.stage_en, bus.stage_flush} !== {1'b1, expPcEn, expEn, expFlush}) begin
        errors++; $display("[TB] FAIL fill_ctrl cyc=%0d got=%b exp=%b", i, {bus.running, bus.pc_en, bus.stage_en, bus.stage_flush}, {1'b1, expPcEn, expEn, expFlush}); end
      tick();
    end
  endtask

  task automatic test_mem_stall();
    logic [NR-1:0] held;
    held = mValid;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if ({bus.pc_en, bus.stage_en, bus.stage_flush} !== {1'b0, NR'(0), NR'(0)}) begin
        errors++; $display("[TB] FAIL stall_ctrl cyc=%0d got=%b exp=0", i, {bus.pc_en, bus.stage_en, bus.stage_flush}); end
      checks++; if (bus.stage_valid !== held) begin
        errors++; $display("[TB] FAIL stall_valid cyc=%0d got=%b exp=%b", i, bus.stage_valid, held); end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({bus.stall_count, bus.flush_count, bus.lu_count} !== expCnt) begin
      errors++; $display("[TB] FAIL stall_counters got=%h exp=%h", {bus.stall_count, bus.flush_count, bus.lu_count}, expCnt); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (bus.stall_count !== CW'(7)) begin
      errors++; $display("[TB] FAIL stall_count7 got=%0d exp=7", bus.stall_count); end
`endif
    checks++; if ({bus.running, bus.pc_en, bus.stage_en} !== {1'b1, 1'b1, ALL}) begin
      errors++; $display("[TB] FAIL stall_release got=%b exp=%b", {bus.running, bus.pc_en, bus.stage_en}, {1'b1, 1'b1, ALL}); end
    tick();
  endtask

  task automatic test_branch();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if ({bus.pc_en, bus.stage_en, bus.stage_flush} !== {1'b1, ALL, NR'(3)}) begin
      errors++; $display("[TB] FAIL branch_ctrl got=%b exp=%b", {bus.pc_en, bus.stage_en, bus.stage_flush}, {1'b1, ALL, NR'(3)}); end
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.stage_valid[1:0] !== 2'b00) begin
      errors++; $display("[TB] FAIL branch_bubble got=%b exp=00", bus.stage_valid[1:0]); end
    checks++; if ({bus.pc_en, bus.stage_flush} !== {1'b1, NR'(0)}) begin
      errors++; $display("[TB] FAIL branch_ignored got=%b exp=%b", {bus.pc_en, bus.stage_flush}, {1'b1, NR'(0)}); end
    checks++; if ({bus.stall_count, bus.flush_count, bus.lu_count} !== expCnt) begin
      errors++; $display("[TB] FAIL branch_counters got=%h exp=%h", {bus.stall_count, bus.flush_count, bus.lu_count}, expCnt); end
    tick();
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 4 && mValid[1:0] != 2'b11; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 1, 0, 1, 5'd3, 5'd5, 5'd5);
    checks++; if ({bus.pc_en, bus.stage_en[1:0], bus.stage_flush[1:0]} !== 5'b0_10_10) begin
      errors++; $display("[TB] FAIL lu_ctrl got=%b exp=01010", {bus.pc_en, bus.stage_en[1:0], bus.stage_flush[1:0]}); end
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd3, 5'd5, 5'd5);
    checks++; if ({bus.pc_en, bus.stage_en, bus.stage_flush} !== {1'b1, ALL, NR'(0)}) begin
      errors++; $display("[TB] FAIL lu_proceed got=%b exp=%b", {bus.pc_en, bus.stage_en, bus.stage_flush}, {1'b1, ALL, NR'(0)}); end
    checks++; if ({bus.stall_count, bus.flush_count, bus.lu_count} !== expCnt) begin
      errors++; $display("[TB] FAIL lu_counters got=%h exp=%h", {bus.stall_count, bus.flush_count, bus.lu_count}, expCnt); end
    tick();
    applyStimulus(0, 0, 0, 1, 1, 1, 5'd0, 5'd0, 5'd0);
    checks++; if ({bus.pc_en, bus.stage_en} !== {1'b1, ALL}) begin
      errors++; $display("[TB] FAIL lu_x0 got=%b exp=%b", {bus.pc_en, bus.stage_en}, {1'b1, ALL}); end
    tick();
  endtask

  task automatic test_back_to_back();
    longint luBefore;
    for (int i = 0; i < 4 && mValid[1:0] != 2'b11; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    luBefore = mLuCnt;
    applyStimulus(0, 0, 1, 1, 1, 0, 5'd7, 5'd1, 5'd7);
    checks++; if ({bus.pc_en, bus.stage_en, bus.stage_flush} !== {1'b1, ALL, NR'(3)}) begin
      errors++; $display("[TB] FAIL b2b_branch_wins got=%b exp=%b", {bus.pc_en, bus.stage_en, bus.stage_flush}, {1'b1, ALL, NR'(3)}); end
    tick();
    for (int i = 0; i < 4 && mValid[1:0] != 2'b11; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    checks++; if ({bus.pc_en, bus.stage_en, bus.stage_flush} !== {1'b0, NR'(0), NR'(0)}) begin
      errors++; $display("[TB] FAIL b2b_stall_hold got=%b exp=0", {bus.pc_en, bus.stage_en, bus.stage_flush}); end
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if ({bus.pc_en, bus.stage_en, bus.stage_flush} !== {1'b1, ALL, NR'(3)}) begin
      errors++; $display("[TB] FAIL b2b_branch_after got=%b exp=%b", {bus.pc_en, bus.stage_en, bus.stage_flush}, {1'b1, ALL, NR'(3)}); end
    checks++; if (mLuCnt != luBefore || {bus.stall_count, bus.flush_count, bus.lu_count} !== expCnt) begin
      errors++; $display("[TB] FAIL b2b_counters got=%h exp=%h", {bus.stall_count, bus.flush_count, bus.lu_count}, expCnt); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      checks++; if ({bus.pc_en, bus.stage_en, bus.stage_flush} !== {expPcEn, expEn, expFlush}) begin
        errors++; $display("[TB] FAIL rand_ctrl cyc=%0d got=%b exp=%b", i, {bus.pc_en, bus.stage_en, bus.stage_flush}, {expPcEn, expEn, expFlush}); end
      checks++; if ({bus.running, bus.stage_valid} !== {expRunning, mValid}) begin
        errors++; $display("[TB] FAIL rand_state cyc=%0d got=%b exp=%b", i, {bus.running, bus.stage_valid}, {expRunning, mValid}); end
      checks++; if ({bus.stall_count, bus.flush_count, bus.lu_count} !== expCnt) begin
        errors++; $display("[TB] FAIL rand_counters cyc=%0d got=%h exp=%h", i, {bus.stall_count, bus.flush_count, bus.lu_count}, expCnt); end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    checks++; if ({bus.running, bus.stage_valid} !== {1'b0, NR'(0)}) begin
      errors++; $display("[TB] FAIL rst_mid_state got=%b exp=0", {bus.running, bus.stage_valid}); end
    checks++; if ({bus.pc_en, bus.stage_en, bus.stage_flush} !== {1'b0, ALL, ALL}) begin
      errors++; $display("[TB] FAIL rst_mid_ctrl got=%b exp=%b", {bus.pc_en, bus.stage_en, bus.stage_flush}, {1'b0, ALL, ALL}); end
    checks++; if ({bus.stall_count, bus.flush_count, bus.lu_count} !== '0) begin
      errors++; $display("[TB] FAIL rst_mid_counters got=%h exp=0", {bus.stall_count, bus.flush_count, bus.lu_count}); end
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({bus.running, bus.pc_en, bus.stage_valid} !== {1'b0, 1'b0, NR'(0)}) begin
      errors++; $display("[TB] FAIL rst_mid_idle got=%b exp=0", {bus.running, bus.pc_en, bus.stage_valid}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_mem_stall();
    test_branch();
    test_load_use();
    test_back_to_back();
    test_random();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
